// File: rtl/ieu_pkg.sv
// rtl/ieu_pkg.sv - shared types and constants for the integer execution unit
package ieu_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic [2:0] ALUSelect;
    logic       SubArith;
    logic       W64;
    logic [2:0] Funct3;
    logic [2:0] ZBBSelect;
    logic [2:0] BALUControl;
    logic [1:0] BSelect;
  } alu_ctrl_t;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/ieu_operand_stage_if.sv
// rtl/ieu_operand_stage_if.sv - decode/forward inputs and execute outputs of the operand stage
interface ieu_operand_stage_if #(parameter int WIDTH = 64);
  import ieu_pkg::*;

  logic             StallE, FlushE;
  logic [WIDTH-1:0] R1D, R2D, ImmExtD, PCD;
  logic [4:0]       Rs1D, Rs2D, RdD;
  logic             ALUSrcAD, ALUSrcBD;
  logic [2:0]       ALUSelectD, Funct3D, ZBBSelectD, BALUControlD;
  logic             SubArithD, W64D;
  logic [1:0]       BSelectD;
  logic             RegWriteD, LoadD, ValidD;
  logic [4:0]       RdM, RdW;
  logic             RegWriteM, RegWriteW;
  logic [WIDTH-1:0] IEUResultM, ResultW;

  logic [WIDTH-1:0] AE, BE, WriteDataE;
  logic [2:0]       ALUSelectE, Funct3E, ZBBSelectE, BALUControlE;
  logic [1:0]       BSelectE;
  logic             SubArithE, W64E;
  logic [4:0]       RdE;
  logic             RegWriteE, LoadE, ValidE;
  logic             LoadUseStallD;
  fwd_sel_t         ForwardAE, ForwardBE;

  modport master (
    output StallE, FlushE, R1D, R2D, ImmExtD, PCD, Rs1D, Rs2D, RdD,
           ALUSrcAD, ALUSrcBD, ALUSelectD, Funct3D, ZBBSelectD, BALUControlD,
           SubArithD, W64D, BSelectD, RegWriteD, LoadD, ValidD,
           RdM, RdW, RegWriteM, RegWriteW, IEUResultM, ResultW,
    input  AE, BE, WriteDataE, ALUSelectE, Funct3E, ZBBSelectE, BALUControlE,
           BSelectE, SubArithE, W64E, RdE, RegWriteE, LoadE, ValidE,
           LoadUseStallD, ForwardAE, ForwardBE
  );

  modport slave (
    input  StallE, FlushE, R1D, R2D, ImmExtD, PCD, Rs1D, Rs2D, RdD,
           ALUSrcAD, ALUSrcBD, ALUSelectD, Funct3D, ZBBSelectD, BALUControlD,
           SubArithD, W64D, BSelectD, RegWriteD, LoadD, ValidD,
           RdM, RdW, RegWriteM, RegWriteW, IEUResultM, ResultW,
    output AE, BE, WriteDataE, ALUSelectE, Funct3E, ZBBSelectE, BALUControlE,
           BSelectE, SubArithE, W64E, RdE, RegWriteE, LoadE, ValidE,
           LoadUseStallD, ForwardAE, ForwardBE
  );

endinterface

// File: rtl/ieu_fwdsel.sv
// rtl/ieu_fwdsel.sv - per-source forwarding select; Memory beats Writeback, x0 never forwarded
module ieu_fwdsel
  import ieu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [4:0]       RsE,
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteW,
  input  logic [WIDTH-1:0] RegE,
  input  logic [WIDTH-1:0] IEUResultM,
  input  logic [WIDTH-1:0] ResultW,
  output fwd_sel_t         Sel,
  output logic [WIDTH-1:0] Fwd
);

  always_comb begin
    Sel = FWD_RF;
    if (RsE != REG_X0) begin
      if (RegWriteM && (RdM == RsE))      Sel = FWD_M;
      else if (RegWriteW && (RdW == RsE)) Sel = FWD_W;
    end
  end

  always_comb begin
    case (Sel)
      FWD_M:   Fwd = IEUResultM;
      FWD_W:   Fwd = ResultW;
      default: Fwd = RegE;
    endcase
  end

endmodule

// File: rtl/ieu_operand_stage.sv
// rtl/ieu_operand_stage.sv - D->E pipeline registers, operand forwarding and load-use detection
module ieu_operand_stage
  import ieu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               reset,
  ieu_operand_stage_if.slave bus
);

  logic [WIDTH-1:0] R1E, R2E, ImmExtE, PCE;
  logic [4:0]       Rs1E, Rs2E, RdE;
  logic             ALUSrcAE, ALUSrcBE, RegWriteE, LoadE, ValidE;
  alu_ctrl_t        ctrl_d, ctrl_e;
  logic             clr, en;
  logic [WIDTH-1:0] fwd_a, fwd_b;

  always_comb begin
    ctrl_d             = '0;
    ctrl_d.ALUSelect   = bus.ALUSelectD;
    ctrl_d.SubArith    = bus.SubArithD;
    ctrl_d.W64         = bus.W64D;
    ctrl_d.Funct3      = bus.Funct3D;
    ctrl_d.ZBBSelect   = bus.ZBBSelectD;
    ctrl_d.BALUControl = bus.BALUControlD;
    ctrl_d.BSelect     = bus.BSelectD;
  end

  // Clear covers both reset and flush, and outranks the stall enable.
  assign clr = ~reset | bus.FlushE;
  assign en  = ~bus.StallE;

  always_ff @(posedge clk) begin
    if (clr) begin
      R1E <= '0; R2E <= '0; ImmExtE <= '0; PCE <= '0;
      Rs1E <= '0; Rs2E <= '0; RdE <= '0;
      ALUSrcAE <= 1'b0; ALUSrcBE <= 1'b0;
      RegWriteE <= 1'b0; LoadE <= 1'b0; ValidE <= 1'b0;
      ctrl_e <= '0;
    end else if (en) begin
      R1E <= bus.R1D; R2E <= bus.R2D; ImmExtE <= bus.ImmExtD; PCE <= bus.PCD;
      Rs1E <= bus.Rs1D; Rs2E <= bus.Rs2D; RdE <= bus.RdD;
      ALUSrcAE <= bus.ALUSrcAD; ALUSrcBE <= bus.ALUSrcBD;
      RegWriteE <= bus.RegWriteD; LoadE <= bus.LoadD; ValidE <= bus.ValidD;
      ctrl_e <= ctrl_d;
    end
  end

  ieu_fwdsel #(.WIDTH(WIDTH)) u_fwd_a (
    .RsE(Rs1E), .RdM(bus.RdM), .RegWriteM(bus.RegWriteM),
    .RdW(bus.RdW), .RegWriteW(bus.RegWriteW), .RegE(R1E),
    .IEUResultM(bus.IEUResultM), .ResultW(bus.ResultW),
    .Sel(bus.ForwardAE), .Fwd(fwd_a)
  );

  ieu_fwdsel #(.WIDTH(WIDTH)) u_fwd_b (
    .RsE(Rs2E), .RdM(bus.RdM), .RegWriteM(bus.RegWriteM),
    .RdW(bus.RdW), .RegWriteW(bus.RegWriteW), .RegE(R2E),
    .IEUResultM(bus.IEUResultM), .ResultW(bus.ResultW),
    .Sel(bus.ForwardBE), .Fwd(fwd_b)
  );

  assign bus.AE         = ALUSrcAE ? PCE : fwd_a;
  assign bus.BE         = ALUSrcBE ? ImmExtE : fwd_b;
  assign bus.WriteDataE = fwd_b;

  assign bus.ALUSelectE   = ctrl_e.ALUSelect;
  assign bus.SubArithE    = ctrl_e.SubArith;
  assign bus.W64E         = ctrl_e.W64;
  assign bus.Funct3E      = ctrl_e.Funct3;
  assign bus.ZBBSelectE   = ctrl_e.ZBBSelect;
  assign bus.BALUControlE = ctrl_e.BALUControl;
  assign bus.BSelectE     = ctrl_e.BSelect;
  assign bus.RdE          = RdE;
  assign bus.RegWriteE    = RegWriteE;
  assign bus.LoadE        = LoadE;
  assign bus.ValidE       = ValidE;

  // Ignores ALUSrc on purpose: a stall on an unused source is harmless.
  assign bus.LoadUseStallD = LoadE & RegWriteE & (RdE != REG_X0) &
                             ((RdE == bus.Rs1D) | (RdE == bus.Rs2D));

endmodule

// File: tb/tb_ieu_operand_stage.sv
// tb/tb_ieu_operand_stage.sv - directed-vector self-checking bench for ieu_operand_stage
module tb_ieu_operand_stage;

  localparam int WIDTH = 64;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  ieu_operand_stage_if #(.WIDTH(WIDTH)) bus ();

  ieu_operand_stage #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_d();
    bus.R1D = '0; bus.R2D = '0; bus.ImmExtD = '0; bus.PCD = '0;
    bus.Rs1D = '0; bus.Rs2D = '0; bus.RdD = '0;
    bus.ALUSrcAD = 0; bus.ALUSrcBD = 0; bus.ALUSelectD = '0;
    bus.SubArithD = 0; bus.W64D = 0; bus.Funct3D = '0; bus.ZBBSelectD = '0;
    bus.BALUControlD = '0; bus.BSelectD = '0;
    bus.RegWriteD = 0; bus.LoadD = 0; bus.ValidD = 0;
  endtask

  task automatic clear_mw();
    bus.RdM = '0; bus.RegWriteM = 0; bus.IEUResultM = '0;
    bus.RdW = '0; bus.RegWriteW = 0; bus.ResultW = '0;
  endtask

  initial begin
    reset = 1'b0;
    bus.StallE = 0; bus.FlushE = 0;
    clear_d();
    clear_mw();

    // reset with random D/M/W activity
    bus.R1D = {$urandom, $urandom}; bus.R2D = {$urandom, $urandom};
    bus.Rs1D = 5'($urandom); bus.Rs2D = 5'($urandom); bus.RdD = 5'($urandom);
    bus.ValidD = 1; bus.RegWriteD = 1; bus.LoadD = 1; bus.ALUSelectD = 3'd6;
    bus.RdM = 5'($urandom); bus.RegWriteM = 1; bus.IEUResultM = {$urandom, $urandom};
    bus.RdW = 5'($urandom); bus.RegWriteW = 1; bus.ResultW = {$urandom, $urandom};
    tick();
    tick();
    check("rst_AE", bus.AE, 0);
    check("rst_BE", bus.BE, 0);
    check("rst_WD", bus.WriteDataE, 0);
    check("rst_valid", bus.ValidE, 0);
    check("rst_regwrite", bus.RegWriteE, 0);
    check("rst_rd", bus.RdE, 0);
    check("rst_alusel", bus.ALUSelectE, 0);
    check("rst_lus", bus.LoadUseStallD, 0);

    // first instruction after release
    reset = 1'b1;
    clear_d();
    clear_mw();
    bus.Rs1D = 5; bus.Rs2D = 6; bus.RdD = 9;
    bus.R1D = 64'h1111; bus.R2D = 64'h2222; bus.PCD = 64'h100; bus.ImmExtD = 64'h10;
    bus.ALUSelectD = 3'b101; bus.Funct3D = 3'b010; bus.BSelectD = 2'b11; bus.W64D = 1;
    bus.ValidD = 1; bus.RegWriteD = 1;
    tick();
    check("first_valid", bus.ValidE, 1);
    check("first_AE", bus.AE, 64'h1111);
    check("first_BE", bus.BE, 64'h2222);
    check("first_alusel", bus.ALUSelectE, 3'b101);
    check("first_funct3", bus.Funct3E, 3'b010);
    check("first_bsel", bus.BSelectE, 2'b11);
    check("first_w64", bus.W64E, 1);
    check("first_rd", bus.RdE, 9);

    // forward priority M over W
    bus.RdM = 5; bus.RegWriteM = 1; bus.IEUResultM = 64'hAAAA;
    bus.RdW = 5; bus.RegWriteW = 1; bus.ResultW = 64'h5555;
    #1;
    check("fwd_M_AE", bus.AE, 64'hAAAA);
    check("fwd_M_BE", bus.BE, 64'h2222);
    bus.RegWriteM = 0;
    #1;
    check("fwd_W_AE", bus.AE, 64'h5555);

    // x0 guard
    bus.Rs1D = 0; bus.R1D = 64'h33; bus.Rs2D = 0; bus.R2D = 0;
    bus.RdM = 0; bus.RegWriteM = 1; bus.IEUResultM = 64'hDEAD;
    bus.RdW = 0; bus.RegWriteW = 1; bus.ResultW = 64'hBEEF;
    tick();
    check("x0_BE", bus.BE, 0);
    check("x0_WD", bus.WriteDataE, 0);
    check("x0_AE", bus.AE, 64'h33);

    // operand muxes; rs2 still forwarded for the store data
    clear_mw();
    bus.ALUSrcAD = 1; bus.PCD = 64'h8000_0000;
    bus.ALUSrcBD = 1; bus.ImmExtD = 64'hFFFF_FFFF_FFFF_FFFC;
    bus.Rs1D = 5; bus.R1D = 64'h1111; bus.Rs2D = 6; bus.R2D = 64'h2222;
    bus.RdM = 6; bus.RegWriteM = 1; bus.IEUResultM = 64'h77;
    tick();
    check("mux_AE", bus.AE, 64'h8000_0000);
    check("mux_BE", bus.BE, 64'hFFFF_FFFF_FFFF_FFFC);
    check("mux_WD", bus.WriteDataE, 64'h77);

    // load-use detection
    clear_mw();
    clear_d();
    bus.LoadD = 1; bus.RegWriteD = 1; bus.ValidD = 1; bus.RdD = 7;
    bus.Rs1D = 1; bus.Rs2D = 2;
    tick();
    bus.Rs1D = 3; bus.Rs2D = 7;
    #1;
    check("lu_rs2", bus.LoadUseStallD, 1);
    bus.Rs2D = 3;
    #1;
    check("lu_nomatch", bus.LoadUseStallD, 0);
    bus.Rs1D = 7;
    #1;
    check("lu_rs1", bus.LoadUseStallD, 1);
    bus.FlushE = 1;
    tick();
    bus.FlushE = 0;
    check("flush_regwrite", bus.RegWriteE, 0);
    check("flush_valid", bus.ValidE, 0);
    check("flush_lus", bus.LoadUseStallD, 0);
    bus.RdD = 0; bus.Rs1D = 0; bus.Rs2D = 0;
    tick();
    check("lu_rd0", bus.LoadUseStallD, 0);

    // stall+flush collision: flush wins
    clear_d();
    bus.RdD = 12; bus.Rs1D = 5; bus.R1D = 64'h44; bus.ALUSelectD = 3'd7;
    bus.RegWriteD = 1; bus.ValidD = 1;
    tick();
    check("pre_coll_rd", bus.RdE, 12);
    bus.StallE = 1; bus.FlushE = 1;
    tick();
    bus.StallE = 0; bus.FlushE = 0;
    check("coll_valid", bus.ValidE, 0);
    check("coll_rd", bus.RdE, 0);
    check("coll_alusel", bus.ALUSelectE, 0);
    check("coll_AE", bus.AE, 0);

    // stall holds E while W forward keeps moving
    clear_d();
    bus.Rs1D = 8; bus.R1D = 64'h99; bus.RdD = 13; bus.ALUSelectD = 3'd3;
    bus.ValidD = 1; bus.RegWriteD = 1;
    tick();
    check("pre_stall_AE", bus.AE, 64'h99);
    bus.StallE = 1;
    bus.RdD = 20; bus.ALUSelectD = 3'd1; bus.R1D = 64'hFFFF; bus.Rs1D = 9;
    bus.RegWriteW = 1; bus.RdW = 8;
    for (int i = 0; i < 3; i++) begin
      bus.ResultW = 64'h1000 + 64'(i);
      tick();
      check("stall_rd", bus.RdE, 13);
      check("stall_alusel", bus.ALUSelectE, 3);
      check("stall_valid", bus.ValidE, 1);
      check("stall_AE", bus.AE, 64'h1000 + 64'(i));
    end
    bus.StallE = 0;
    tick();
    check("unstall_rd", bus.RdE, 20);
    check("unstall_AE", bus.AE, 64'hFFFF);

    // reset mid-stream discards the pending instruction
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midrst_valid", bus.ValidE, 0);
    check("midrst_rd", bus.RdE, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
